// File: rtl/vector_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vector_pkg
//  Description : Shared types and constants for the enemy fleet logic:
//                lane state encoding, enemy range defaults, sprite addresses
//                and a small popcount helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package vector_pkg;

    // Enemy x range of the playfield.
    localparam int ENEMY_X_MIN = 0;
    localparam int ENEMY_X_MAX = 255;

    // Defaults for the lane spawn point, nuke threshold and sprites.
    localparam int DEF_X_START   = 10;
    localparam int DEF_X_TARGET  = 200;
    localparam int DEF_X_STEP    = 1;
    localparam logic [15:0] DEF_ADR_ENEMY   = 16'h0000;
    localparam logic [15:0] DEF_ADR_EXPLODE = 16'h0400;

    // Per-lane state encoding.
    typedef enum logic [1:0] {
        LANE_IDLE = 2'd0,
        LANE_FLY  = 2'd1,
        LANE_BOOM = 2'd2
    } lane_state_t;

    // Number of set bits in a lane mask (up to 8 lanes).
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int k = 0; k < 8; k++) begin
            n = n + {3'd0, v[k]};
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/enemy_lane.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_lane
//  Description : One enemy/base lane: spawn, advance toward the base,
//                explosion animation timer and sticky base-nuked flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module enemy_lane
    import vector_pkg::*;
#(
    parameter int OUT_WIDTH      = 8,
    parameter int ADDRESSWIDTH   = 16,
    parameter int X_START        = DEF_X_START,
    parameter int X_TARGET       = DEF_X_TARGET,
    parameter int X_STEP         = DEF_X_STEP,
    parameter int Y_POS          = 40,
    parameter int DESTROY_CYCLES = 5_000_000,
    parameter logic [ADDRESSWIDTH-1:0] ADR_ENEMY   = DEF_ADR_ENEMY,
    parameter logic [ADDRESSWIDTH-1:0] ADR_EXPLODE = DEF_ADR_EXPLODE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    spawn_tick,
    input  logic                    move_tick,
    input  logic                    hit,
    input  logic                    freeze,
    output logic [OUT_WIDTH-1:0]    x,
    output logic [OUT_WIDTH-1:0]    y,
    output logic                    visible,
    output logic [ADDRESSWIDTH-1:0] adr,
    output logic                    nuked,
    output logic                    flying
);

    localparam int TW = (DESTROY_CYCLES > 1) ? $clog2(DESTROY_CYCLES) : 1;
    localparam logic [TW-1:0]        TIMER_LOAD = TW'(DESTROY_CYCLES - 1);
    localparam logic [OUT_WIDTH-1:0] X_RELOAD   = OUT_WIDTH'(X_START);
    localparam logic [OUT_WIDTH:0]   STEP_EXT   = (OUT_WIDTH+1)'(X_STEP);
    localparam logic [OUT_WIDTH:0]   TARGET_EXT = (OUT_WIDTH+1)'(X_TARGET);

    lane_state_t       state;
    logic [TW-1:0]     timer;
    logic [OUT_WIDTH:0] x_next;

    // One extra bit so a step past the top of the range still reads as >= target.
    assign x_next = {1'b0, x} + STEP_EXT;
    assign flying = (state == LANE_FLY);

    // Lane y is a fixed per-lane constant held in a register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) y <= OUT_WIDTH'(Y_POS);
        else     y <= y;
    end

    // Lane FSM with registered x, sprite address, visibility and nuke flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= LANE_IDLE;
            timer   <= '0;
            x       <= X_RELOAD;
            visible <= 1'b0;
            adr     <= ADR_ENEMY;
            nuked   <= 1'b0;
        end else begin
            case (state)
                LANE_IDLE: begin
                    if (spawn_tick && !nuked && !freeze) begin
                        state   <= LANE_FLY;
                        x       <= X_RELOAD;
                        visible <= 1'b1;
                        adr     <= ADR_ENEMY;
                    end
                end
                LANE_FLY: begin
                    // A hit beats a simultaneous move, so a hit enemy never nukes.
                    if (hit) begin
                        state <= LANE_BOOM;
                        timer <= TIMER_LOAD;
                        adr   <= ADR_EXPLODE;
                    end else if (move_tick && !freeze) begin
                        if (x_next >= TARGET_EXT) begin
                            state   <= LANE_IDLE;
                            nuked   <= 1'b1;
                            visible <= 1'b0;
                            x       <= X_RELOAD;
                        end else begin
                            x <= x_next[OUT_WIDTH-1:0];
                        end
                    end
                end
                LANE_BOOM: begin
                    if (timer == '0) begin
                        state   <= LANE_IDLE;
                        visible <= 1'b0;
                        x       <= X_RELOAD;
                        adr     <= ADR_ENEMY;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    state   <= LANE_IDLE;
                    visible <= 1'b0;
                    x       <= X_RELOAD;
                    adr     <= ADR_ENEMY;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/enemy_fleet_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : enemy_fleet_ctrl
//  Description : NUM_LANES enemy lanes plus saturating kill counter,
//                difficulty level, lives budget and sticky game-over latch.
//  Revision    : 1.0 - initial release
// ============================================================================
module enemy_fleet_ctrl
    import vector_pkg::*;
#(
    parameter int NUM_LANES      = 3,
    parameter int OUT_WIDTH      = 8,
    parameter int ADDRESSWIDTH   = 16,
    parameter int X_START        = DEF_X_START,
    parameter int X_TARGET       = DEF_X_TARGET,
    parameter int X_STEP         = DEF_X_STEP,
    parameter int Y_LANE0        = 40,
    parameter int Y_LANE_STEP    = 50,
    parameter int DESTROY_CYCLES = 5_000_000,
    parameter int LIVES          = 2,
    parameter int LEVEL_SHIFT    = 3,
    parameter logic [ADDRESSWIDTH-1:0] ADR_ENEMY   = DEF_ADR_ENEMY,
    parameter logic [ADDRESSWIDTH-1:0] ADR_EXPLODE = DEF_ADR_EXPLODE
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_LANES-1:0]              spawn_tick,
    input  logic [NUM_LANES-1:0]              move_tick,
    input  logic [NUM_LANES-1:0]              hit,
    output logic [NUM_LANES*OUT_WIDTH-1:0]    x_enemy,
    output logic [NUM_LANES*OUT_WIDTH-1:0]    y_enemy,
    output logic [NUM_LANES-1:0]              spawn_enemy,
    output logic [NUM_LANES*ADDRESSWIDTH-1:0] adr_enemy,
    output logic [NUM_LANES-1:0]              base_nuked,
    output logic [OUT_WIDTH-1:0]              killcount,
    output logic [OUT_WIDTH-1:0]              level,
    output logic                              game_over
);

    localparam logic [OUT_WIDTH+3:0] KILL_MAX = {4'd0, {OUT_WIDTH{1'b1}}};

    logic [NUM_LANES-1:0] fly_mask;
    logic [7:0]           hit_pad;
    logic [7:0]           nuked_pad;
    logic [3:0]           hit_count;
    logic [3:0]           nuked_count;
    logic [OUT_WIDTH+3:0] kill_sum;

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
            enemy_lane #(
                .OUT_WIDTH      (OUT_WIDTH),
                .ADDRESSWIDTH   (ADDRESSWIDTH),
                .X_START        (X_START),
                .X_TARGET       (X_TARGET),
                .X_STEP         (X_STEP),
                .Y_POS          (Y_LANE0 + i * Y_LANE_STEP),
                .DESTROY_CYCLES (DESTROY_CYCLES),
                .ADR_ENEMY      (ADR_ENEMY),
                .ADR_EXPLODE    (ADR_EXPLODE)
            ) u_lane (
                .clk        (clk),
                .rst        (rst),
                .spawn_tick (spawn_tick[i]),
                .move_tick  (move_tick[i]),
                .hit        (hit[i]),
                .freeze     (game_over),
                .x          (x_enemy[i*OUT_WIDTH +: OUT_WIDTH]),
                .y          (y_enemy[i*OUT_WIDTH +: OUT_WIDTH]),
                .visible    (spawn_enemy[i]),
                .adr        (adr_enemy[i*ADDRESSWIDTH +: ADDRESSWIDTH]),
                .nuked      (base_nuked[i]),
                .flying     (fly_mask[i])
            );
        end
    endgenerate

    // Only hits on flying enemies score; masks are widened for the popcount helper.
    always_comb begin
        hit_pad   = 8'd0;
        nuked_pad = 8'd0;
        hit_pad[NUM_LANES-1:0]   = hit & fly_mask;
        nuked_pad[NUM_LANES-1:0] = base_nuked;
        hit_count   = popcount8(hit_pad);
        nuked_count = popcount8(nuked_pad);
        kill_sum    = {4'd0, killcount} + {{OUT_WIDTH{1'b0}}, hit_count};
    end

    // Saturating kill counter, level derived from the previous count, sticky game over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            killcount <= '0;
            level     <= '0;
            game_over <= 1'b0;
        end else begin
            killcount <= (kill_sum > KILL_MAX) ? {OUT_WIDTH{1'b1}}
                                               : kill_sum[OUT_WIDTH-1:0];
            level     <= killcount >> LEVEL_SHIFT;
            if (int'(nuked_count) >= LIVES) begin
                game_over <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_enemy_fleet_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_enemy_fleet_ctrl
//  Description : Directed self-checking bench for enemy_fleet_ctrl with a
//                shortened explosion animation (4 cycles).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_enemy_fleet_ctrl;

    logic        clk;
    logic        rst;
    logic [2:0]  spawn_tick;
    logic [2:0]  move_tick;
    logic [2:0]  hit;
    logic [23:0] x_enemy;
    logic [23:0] y_enemy;
    logic [2:0]  spawn_enemy;
    logic [47:0] adr_enemy;
    logic [2:0]  base_nuked;
    logic [7:0]  killcount;
    logic [7:0]  level;
    logic        game_over;

    int checks = 0;
    int errors = 0;

    enemy_fleet_ctrl #(
        .NUM_LANES      (3),
        .OUT_WIDTH      (8),
        .ADDRESSWIDTH   (16),
        .X_START        (10),
        .X_TARGET       (200),
        .X_STEP         (1),
        .Y_LANE0        (40),
        .Y_LANE_STEP    (50),
        .DESTROY_CYCLES (4),
        .LIVES          (2),
        .LEVEL_SHIFT    (3),
        .ADR_ENEMY      (16'h0000),
        .ADR_EXPLODE    (16'h0400)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .spawn_tick  (spawn_tick),
        .move_tick   (move_tick),
        .hit         (hit),
        .x_enemy     (x_enemy),
        .y_enemy     (y_enemy),
        .spawn_enemy (spawn_enemy),
        .adr_enemy   (adr_enemy),
        .base_nuked  (base_nuked),
        .killcount   (killcount),
        .level       (level),
        .game_over   (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of pulses, then sample just after the edge.
    task automatic step(input logic [2:0] s, input logic [2:0] m, input logic [2:0] h);
        spawn_tick = s;
        move_tick  = m;
        hit        = h;
        @(posedge clk);
        #1;
        spawn_tick = 3'b000;
        move_tick  = 3'b000;
        hit        = 3'b000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    function automatic logic [7:0] lane_x(input int i);
        return x_enemy[i*8 +: 8];
    endfunction

    function automatic logic [15:0] lane_adr(input int i);
        return adr_enemy[i*16 +: 16];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        spawn_tick = 3'b000;
        move_tick  = 3'b000;
        hit        = 3'b000;
        #3;
        // Asynchronous reset values before any clock edge.
        check("rst_x",     {40'd0, x_enemy},     {40'd0, 24'h0A0A0A});
        check("rst_y",     {40'd0, y_enemy},     {40'd0, 8'd140, 8'd90, 8'd40});
        check("rst_vis",   {61'd0, spawn_enemy}, 64'd0);
        check("rst_adr",   {16'd0, adr_enemy},   64'd0);
        check("rst_nuked", {61'd0, base_nuked},  64'd0);
        check("rst_kill",  {56'd0, killcount},   64'd0);
        check("rst_level", {56'd0, level},       64'd0);
        check("rst_go",    {63'd0, game_over},   64'd0);
        do_reset();

        // ---- Spawn and advance lane 0 until its base is nuked ----
        step(3'b001, 3'b000, 3'b000);
        check("spawn_vis", {61'd0, spawn_enemy}, 64'd1);
        check("spawn_x",   {56'd0, lane_x(0)},   64'd10);
        for (int k = 1; k <= 189; k++) begin
            step(3'b000, 3'b001, 3'b000);
            check("adv_x", {56'd0, lane_x(0)}, 64'(10 + k));
        end
        step(3'b000, 3'b001, 3'b000);
        check("nuke_flag", {61'd0, base_nuked},  64'd1);
        check("nuke_vis",  {61'd0, spawn_enemy}, 64'd0);
        check("nuke_x",    {56'd0, lane_x(0)},   64'd10);
        step(3'b001, 3'b000, 3'b000);
        check("nuked_spawn_ign", {61'd0, spawn_enemy}, 64'd0);
        step(3'b000, 3'b000, 3'b000);
        check("one_nuke_no_go", {63'd0, game_over}, 64'd0);

        // ---- Hit and explosion animation on lane 1 ----
        do_reset();
        step(3'b010, 3'b000, 3'b000);
        step(3'b000, 3'b000, 3'b010);
        check("hit_adr",  {48'd0, lane_adr(1)},  64'h0400);
        check("hit_kill", {56'd0, killcount},    64'd1);
        check("boom_vis0", {61'd0, spawn_enemy}, 64'b010);
        step(3'b000, 3'b000, 3'b010);
        check("boom_hit_ign", {56'd0, killcount}, 64'd1);
        check("boom_vis1", {61'd0, spawn_enemy},  64'b010);
        step(3'b000, 3'b000, 3'b000);
        check("boom_vis2", {61'd0, spawn_enemy},  64'b010);
        step(3'b000, 3'b000, 3'b000);
        check("boom_vis3", {61'd0, spawn_enemy},  64'b010);
        step(3'b000, 3'b000, 3'b000);
        check("boom_end_vis", {61'd0, spawn_enemy}, 64'd0);
        check("boom_end_adr", {48'd0, lane_adr(1)}, 64'h0000);
        step(3'b000, 3'b000, 3'b010);
        check("idle_hit_ign", {56'd0, killcount}, 64'd1);

        // ---- Simultaneous hit and move on all lanes, lane 0 at the edge ----
        do_reset();
        step(3'b111, 3'b000, 3'b000);
        for (int k = 1; k <= 189; k++) begin
            step(3'b000, 3'b001, 3'b000);
        end
        check("edge_x", {56'd0, lane_x(0)}, 64'd199);
        step(3'b000, 3'b111, 3'b111);
        check("multi_kill",   {56'd0, killcount},   64'd3);
        check("multi_nonuke", {61'd0, base_nuked},  64'd0);
        check("multi_adr0",   {48'd0, lane_adr(0)}, 64'h0400);
        check("multi_adr2",   {48'd0, lane_adr(2)}, 64'h0400);
        check("multi_vis",    {61'd0, spawn_enemy}, 64'b111);

        // ---- Saturating kill counter and level ----
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(3'b010, 3'b000, 3'b000);
            step(3'b000, 3'b000, 3'b010);
            check("sat_kill", {56'd0, killcount}, (i + 1 > 255) ? 64'd255 : 64'(i + 1));
            repeat (4) step(3'b000, 3'b000, 3'b000);
            if (i == 7) begin
                check("level_8", {56'd0, level}, 64'd1);
            end
        end
        check("sat_final", {56'd0, killcount}, 64'd255);
        check("sat_level", {56'd0, level},     64'd31);

        // ---- Game over after two nuked bases ----
        do_reset();
        step(3'b111, 3'b000, 3'b000);
        for (int k = 1; k <= 189; k++) begin
            step(3'b000, 3'b101, 3'b000);
        end
        step(3'b000, 3'b001, 3'b000);
        check("go_nuke0", {61'd0, base_nuked}, 64'b001);
        step(3'b000, 3'b100, 3'b000);
        check("go_nuke2",   {61'd0, base_nuked}, 64'b101);
        check("go_not_yet", {63'd0, game_over},  64'd0);
        step(3'b000, 3'b000, 3'b000);
        check("go_set", {63'd0, game_over}, 64'd1);
        step(3'b000, 3'b010, 3'b000);
        check("go_freeze_x", {56'd0, lane_x(1)}, 64'd10);
        step(3'b000, 3'b000, 3'b010);
        check("go_hit_kill", {56'd0, killcount}, 64'd1);
        repeat (4) step(3'b000, 3'b000, 3'b000);
        check("go_boom_done", {61'd0, spawn_enemy}, 64'd0);
        step(3'b010, 3'b000, 3'b000);
        check("go_spawn_ign", {61'd0, spawn_enemy}, 64'd0);
        check("go_sticky",    {63'd0, game_over},   64'd1);

        // Asynchronous reset asserted between clock edges.
        #2;
        rst = 1'b1;
        #1;
        check("arst_go",    {63'd0, game_over},  64'd0);
        check("arst_nuked", {61'd0, base_nuked}, 64'd0);
        check("arst_kill",  {56'd0, killcount},  64'd0);
        check("arst_vis",   {61'd0, spawn_enemy}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/enemy_fleet_ctrl.md
Name: enemy_fleet_ctrl

Overview:
- Parametrised N-lane enemy controller; generalises the three fixed enemy/base channels of the game logic into NUM_LANES identical lanes.
- Per lane: spawn, advance, explosion animation and base-nuked tracking.
- Also maintains a saturating kill counter, a difficulty level, a lives budget and a game-over latch.
- Sits between the timer cluster and missile unit (inputs) and memory_manage (outputs).

Parameters:
- NUM_LANES, 3, number of enemy/base lanes (1..8).
- OUT_WIDTH, 8, coordinate and killcount width.
- ADDRESSWIDTH, 16, sprite address width.
- X_START, 8'd10, x position on spawn.
- X_TARGET, 8'd200, x at or beyond which the lane's base is nuked.
- X_STEP, 1, x increment per move tick.
- Y_LANE0, 8'd40, y of lane 0.
- Y_LANE_STEP, 8'd50, y spacing between lanes; lane i y = Y_LANE0 + i*Y_LANE_STEP, truncated to OUT_WIDTH.
- DESTROY_CYCLES, 5_000_000, explosion animation length in clk cycles.
- LIVES, 2, number of nuked bases that triggers game over.
- LEVEL_SHIFT, 3, level = killcount >> LEVEL_SHIFT.
- ADR_ENEMY, 16'h0000, sprite address while flying.
- ADR_EXPLODE, 16'h0400, sprite address while exploding.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- spawn_tick  in  NUM_LANES  per-lane spawn request pulse
- move_tick  in  NUM_LANES  per-lane advance pulse
- hit  in  NUM_LANES  per-lane missile hit pulse
- x_enemy  out  NUM_LANES*OUT_WIDTH  packed x, lane i at [i*OUT_WIDTH +: OUT_WIDTH]
- y_enemy  out  NUM_LANES*OUT_WIDTH  packed y, same packing
- spawn_enemy  out  NUM_LANES  lane visible (FLY or BOOM)
- adr_enemy  out  NUM_LANES*ADDRESSWIDTH  packed sprite address
- base_nuked  out  NUM_LANES  sticky per-lane base destroyed flag
- killcount  out  OUT_WIDTH  saturating hits counter
- level  out  OUT_WIDTH  difficulty level
- game_over  out  1  sticky end-of-game flag

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- All outputs registered.
- Reset values: x_enemy = X_START, y_enemy = lane y, spawn_enemy = 0, adr_enemy = ADR_ENEMY, base_nuked = 0, killcount = 0, level = 0, game_over = 0; all lanes IDLE.
- Reset mid-operation immediately returns every lane to IDLE and clears the counters.
- Per-lane FSM:
  - IDLE: spawn_tick[i] && !base_nuked[i] && !game_over -> FLY next cycle; x = X_START, spawn_enemy = 1, adr = ADR_ENEMY.
  - FLY, priority order:
    1. hit[i] -> BOOM, timer loads DESTROY_CYCLES-1, adr = ADR_EXPLODE, killcount +1.
    2. move_tick[i] -> compute x+X_STEP at OUT_WIDTH+1 bits. If result >= X_TARGET: base_nuked[i] = 1, lane -> IDLE, spawn_enemy = 0, x reloads X_START. Otherwise x = x+X_STEP.
  - BOOM: timer decrements each cycle; at 0 -> IDLE, spawn_enemy = 0, x = X_START. hit and move ticks are ignored.
- Ignored inputs:
  - spawn_tick in FLY or BOOM.
  - hit in IDLE or BOOM (no killcount increment).
  - All ticks on a lane with base_nuked set.
- Same-cycle events:
  - hit and move_tick together: hit wins, no nuke.
  - Multiple lanes hit in the same cycle: killcount adds popcount(hit & FLY mask), saturating at 2^OUT_WIDTH-1.
- level is registered killcount >> LEVEL_SHIFT; it lags killcount by one cycle.
- game_over is set the cycle after popcount(base_nuked) >= LIVES. It is sticky until rst.
  - While set, no new spawns occur.
  - FLY lanes freeze position but still accept hits.
  - BOOM lanes complete their animation.
- Latency: input pulse to output change is 1 cycle.

Decomposition:
- Lane state enum (IDLE, FLY, BOOM) and default X_START/X_TARGET/ADR constants belong in vector_pkg alongside the existing enemy range constants.
- One sub-module, enemy_lane: FSM, x register and animation timer. Instantiate it NUM_LANES times with a generate loop.
- Kill counting, level, lives and game_over logic stay in the top.

Test Plan:
- Spawn/advance, NUM_LANES=3, X_STEP=1, X_TARGET=200, X_START=10: spawn_tick[0], then 190 move_ticks -> x_enemy[0] goes 10..199. The 190th tick sets base_nuked[0]=1, spawn_enemy[0]=0 and x reloads 10. A later spawn_tick[0] is ignored.
- Hit and animation, DESTROY_CYCLES=4: lane1 in FLY, pulse hit[1] -> next cycle adr = ADR_EXPLODE, killcount=1. spawn_enemy[1] stays 1 for exactly 4 cycles, then 0. hit[1] during BOOM leaves killcount at 1.
- Simultaneous events: all three lanes FLY; hit=3'b111 with move_tick=3'b111 while lane0 is at x=199 -> killcount +3, base_nuked stays 0.
- Saturation/level, OUT_WIDTH=8, LEVEL_SHIFT=3: 300 spawn/hit cycles -> killcount sticks at 255, level=31.
- Game over, LIVES=2: nuke lanes 0 and 2 -> game_over=1 one cycle after the second nuke. spawn_tick[1] is ignored, and rst clears all outputs asynchronously mid-cycle.
